// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, frame geometry and a clog2 helper
// used to size bit-period counters (also intended for a future uart_tx).
package uart_pkg;

    localparam int DATA_BITS   = 8;
    localparam int SYNC_STAGES = 2;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_PARITY    = 3'd3;
    localparam logic [2:0] ST_STOP      = 3'd4;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for an asynchronous input; resets to 1 so an idle
// (high) serial line never looks like a start bit coming out of reset.
module uart_rx_sync
    import uart_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 LSB first, mid-bit sampling with a one-byte output buffer.
// Define UART_RX_PARITY_EN to add a parity bit, PARITY_ODD and rx_parity_err.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ   = 50000000,
    parameter int BIT_RATE = 115200
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic       clk,
    input  logic       m_areset,
    input  logic       uart_rxd,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic       rx_frame_err,
    output logic       rx_overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic       rx_parity_err
`endif
);

    localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
    localparam int CNT_W          = clog2(CYCLES_PER_BIT);
    localparam int IDX_W          = clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CYCLES_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    generate
        if (CYCLES_PER_BIT < 4) begin : g_cfg_check
            $error("uart_rx: CLK_HZ/BIT_RATE must be at least 4");
        end
    endgenerate

    logic rxs;

    uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (m_areset),
        .d   (uart_rxd),
        .q   (rxs)
    );

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             valid_q, valid_d;
    logic [7:0]       data_q, data_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;
    logic             deliver;
`ifdef UART_RX_PARITY_EN
    logic             par_q, par_d;
    logic             perr_q, perr_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        ferr_d  = 1'b0;
        deliver = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!rxs) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rxs ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d          = '0;
                    shift_d[bit_q] = rxs;
                    if (bit_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d = bit_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    par_d   = rxs;
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            ST_STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d = '0;
                    // Returning to IDLE at mid-stop lets a start edge in the
                    // second half of the stop bit begin the next frame.
                    if (rxs) begin
                        state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                        if ((^shift_q ^ par_q) != PARITY_ODD) begin
                            perr_d = 1'b1;
                        end else begin
                            deliver = 1'b1;
                        end
`else
                        deliver = 1'b1;
`endif
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_IDLE: begin
                if (rxs) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output buffer: a delivery may replace a byte being accepted this cycle,
    // otherwise a full buffer drops the new byte and flags an overrun.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ovr_d   = 1'b0;
        if (deliver) begin
            if (!valid_q || rx_ready) begin
                valid_d = 1'b1;
                data_d  = shift_q;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge m_areset) begin
        if (m_areset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign rx_valid     = valid_q;
    assign rx_data      = data_q;
    assign rx_frame_err = ferr_q;
    assign rx_overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
    assign rx_parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed scenarios plus randomized frames, checked against
// a byte-level model (expected byte queue and expected error-pulse counts).
module tb_uart_rx;

    localparam int CLK_HZ   = 1600000;
    localparam int BIT_RATE = 100000;
    localparam int CPB      = CLK_HZ / BIT_RATE;
    localparam int LAT      = 2 + CPB / 2 + 9 * CPB + 1;

    logic       clk = 1'b0;
    logic       m_areset = 1'b1;
    logic       uart_rxd = 1'b1;
    logic       rx_ready = 1'b1;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_frame_err;
    logic       rx_overrun;
`ifdef UART_RX_PARITY_EN
    logic       rx_parity_err;
`endif

    uart_rx #(.CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE)) dut (
        .clk          (clk),
        .m_areset     (m_areset),
        .uart_rxd     (uart_rxd),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun)
`ifdef UART_RX_PARITY_EN
        ,
        .rx_parity_err(rx_parity_err)
`endif
    );

    // clock / reset bookkeeping
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int start_cyc = 0;
    int last_rise = -1;
    int valid_hi  = 0;
    int ferr_seen = 0;
    int ovr_seen  = 0;
    int exp_ferr  = 0;
    int exp_ovr   = 0;
    logic valid_prev = 1'b0;
    logic rnd_on = 1'b0;
    logic [7:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // scoreboard / monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (!m_areset) begin
            if (rx_valid) valid_hi++;
            if (rx_valid && !valid_prev) last_rise = cyc;
            if (rx_frame_err) ferr_seen++;
            if (rx_overrun) ovr_seen++;
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) chk("unexpected_byte", exp_q.size(), 1);
                else chk("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
            end
        end
        valid_prev = rx_valid;
    end

    // driver tasks: all line changes land 1 time unit after a posedge
    task automatic drive(input logic v, input int n);
        uart_rxd = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int nbits);
        start_cyc = cyc;
        drive(1'b0, CPB);
        for (int i = 0; i < nbits; i++) drive(d[i], CPB);
        if (nbits == 8) drive(stop, CPB);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 12 * CPB) begin
            @(posedge clk);
            n++;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, {31'd0, rx_valid}, 0);
        chk({tag, "_data"}, {24'd0, rx_data}, 0);
        chk({tag, "_frame_err"}, {31'd0, rx_frame_err}, 0);
        chk({tag, "_overrun"}, {31'd0, rx_overrun}, 0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b_v, b_f, b_o;
        logic [7:0] d;
        logic bad;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk);
        #1;
        m_areset = 1'b0;
        drive(1'b1, 10);

        // 0xA5: latency, single-cycle valid, no errors
        b_v = valid_hi; b_f = ferr_seen; b_o = ovr_seen; last_rise = -1;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 8);
        drive(1'b1, CPB);
        wait_drain("t1_drain");
        chk("t1_latency", last_rise - start_cyc, LAT);
        chk("t1_valid_cycles", valid_hi - b_v, 1);
        chk("t1_frame_err", ferr_seen - b_f, 0);
        chk("t1_overrun", ovr_seen - b_o, 0);

        // short glitch then 0x3C
        b_v = valid_hi; b_f = ferr_seen;
        drive(1'b0, 4);
        drive(1'b1, 30);
        chk("t2_glitch_valid", valid_hi - b_v, 0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 8);
        drive(1'b1, CPB);
        wait_drain("t2_drain");
        chk("t2_frame_err", ferr_seen - b_f, 0);

        // bad stop + break, then 0x81
        b_v = valid_hi; b_f = ferr_seen;
        send_frame(8'h55, 1'b0, 8);
        drive(1'b0, 40);
        drive(1'b1, 20);
        exp_ferr++;
        chk("t3_frame_err", ferr_seen - b_f, 1);
        chk("t3_no_valid", valid_hi - b_v, 0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, 8);
        drive(1'b1, CPB);
        wait_drain("t3_drain");
        chk("t3_frame_err_total", ferr_seen - b_f, 1);

        // overrun with consumer stalled
        rx_ready = 1'b0;
        b_o = ovr_seen;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 8);
        drive(1'b1, 5);
        chk("t4_first_data", {24'd0, rx_data}, 32'h11);
        send_frame(8'h22, 1'b1, 8);
        drive(1'b1, CPB);
        exp_ovr++;
        @(negedge clk);
        chk("t4_overrun", ovr_seen - b_o, 1);
        chk("t4_data_held", {24'd0, rx_data}, 32'h11);
        chk("t4_valid_held", {31'd0, rx_valid}, 1);
        @(posedge clk);
        #1;
        rx_ready = 1'b1;
        wait_drain("t4_drain");
        drive(1'b1, 4);
        @(negedge clk);
        chk("t4_valid_cleared", {31'd0, rx_valid}, 0);
        chk("t4_data_kept", {24'd0, rx_data}, 32'h11);
        @(posedge clk);
        #1;

        // back-to-back frames
        b_f = ferr_seen; b_o = ovr_seen;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1, 8);
        send_frame(8'hFF, 1'b1, 8);
        drive(1'b1, CPB);
        wait_drain("t5_drain");
        chk("t5_frame_err", ferr_seen - b_f, 0);
        chk("t5_overrun", ovr_seen - b_o, 0);

        // reset mid-frame with a byte sitting in the buffer
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
        send_frame(8'h5A, 1'b1, 8);
        drive(1'b1, 4);
        @(negedge clk);
        chk("t6_buffered", {31'd0, rx_valid}, 1);
        @(posedge clk);
        #1;
        d = 8'h99;
        send_frame(d, 1'b1, 4);
        drive(d[4], CPB / 2);
        m_areset = 1'b1;
        uart_rxd = 1'b1;
        @(negedge clk);
        chk_reset_outputs("t6_in_reset");
        rx_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        m_areset = 1'b0;
        drive(1'b1, 20);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1, 8);
        drive(1'b1, CPB);
        wait_drain("t6_drain");

        // randomized frames with a randomly stalling consumer
        b_f = ferr_seen; b_o = ovr_seen;
        b_v = 0;
        rnd_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    d   = 8'($urandom_range(0, 255));
                    bad = ($urandom_range(0, 5) == 0);
                    if (bad) begin
                        send_frame(d, 1'b0, 8);
                        drive(1'b0, $urandom_range(0, 30));
                        drive(1'b1, $urandom_range(2, 12));
                        b_v++;
                        exp_ferr++;
                    end else begin
                        exp_q.push_back(d);
                        send_frame(d, 1'b1, 8);
                        drive(1'b1, $urandom_range(0, 12));
                    end
                end
                rnd_on = 1'b0;
            end
            begin
                while (rnd_on) begin
                    @(posedge clk);
                    #1;
                    rx_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        rx_ready = 1'b1;
        drive(1'b1, CPB);
        wait_drain("rnd_drain");
        chk("rnd_frame_err", ferr_seen - b_f, b_v);
        chk("rnd_overrun", ovr_seen - b_o, 0);

        chk("total_frame_err", ferr_seen, exp_ferr);
        chk("total_overrun", ovr_seen, exp_ovr);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
